// File: rtl/gpio_ext_pkg.sv
// Shared constants for the 16-pin CSR-mapped GPIO controller:
// register offsets, interrupt mode encodings and field widths.
package gpio_ext_pkg;

  localparam int unsigned MAX_GPIOS  = 16;
  localparam int unsigned DEBOUNCE_W = 8;
  localparam int unsigned CSR_AW     = 5;
  localparam int unsigned CSR_DW     = 8;
  localparam int unsigned OFF_W      = 4;

  localparam logic [OFF_W-1:0] GPIO_DIR_LO   = 4'h0;
  localparam logic [OFF_W-1:0] GPIO_DIR_HI   = 4'h1;
  localparam logic [OFF_W-1:0] GPIO_OUT_LO   = 4'h2;
  localparam logic [OFF_W-1:0] GPIO_OUT_HI   = 4'h3;
  localparam logic [OFF_W-1:0] GPIO_IN_LO    = 4'h4;
  localparam logic [OFF_W-1:0] GPIO_IN_HI    = 4'h5;
  localparam logic [OFF_W-1:0] GPIO_IE_LO    = 4'h6;
  localparam logic [OFF_W-1:0] GPIO_IE_HI    = 4'h7;
  localparam logic [OFF_W-1:0] GPIO_IP_LO    = 4'h8;
  localparam logic [OFF_W-1:0] GPIO_IP_HI    = 4'h9;
  localparam logic [OFF_W-1:0] GPIO_IMODE_0  = 4'hA;
  localparam logic [OFF_W-1:0] GPIO_IMODE_1  = 4'hB;
  localparam logic [OFF_W-1:0] GPIO_IMODE_2  = 4'hC;
  localparam logic [OFF_W-1:0] GPIO_IMODE_3  = 4'hD;
  localparam logic [OFF_W-1:0] GPIO_DEBOUNCE = 4'hE;

  typedef enum logic [1:0] {
    IMODE_BOTH  = 2'b00,
    IMODE_RISE  = 2'b01,
    IMODE_FALL  = 2'b10,
    IMODE_LEVEL = 2'b11
  } imode_e;

  // One-hot-per-implemented-pin mask, 1 bit per pin.
  function automatic logic [MAX_GPIOS-1:0] pin_mask(input int unsigned n);
    logic [MAX_GPIOS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_GPIOS; i++) m[i] = (i < n);
    return m;
  endfunction

  // Same mask spread over the 2-bit-per-pin IMODE field.
  function automatic logic [2*MAX_GPIOS-1:0] imode_mask(input int unsigned n);
    logic [2*MAX_GPIOS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_GPIOS; i++) m[2*i +: 2] = (i < n) ? 2'b11 : 2'b00;
    return m;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-pin debounce: filtered follows in_sync after limit+1 stable cycles.
module gpio_debounce
  import gpio_ext_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_sync,
  input  logic [DEBOUNCE_W-1:0] limit,
  output logic                  filtered,
  output logic                  toggle_c
);

  logic [DEBOUNCE_W-1:0] cnt;
  logic                  mismatch;

  assign mismatch = in_sync ^ filtered;
  // >= so that shrinking the limit mid-count fires on the next edge
  assign toggle_c = mismatch && (cnt >= limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (toggle_c) begin
      cnt      <= '0;
      filtered <= ~filtered;
    end else if (mismatch) begin
      cnt      <= cnt + DEBOUNCE_W'(1);
    end else begin
      cnt      <= '0;
    end
  end

endmodule

// File: rtl/sync_edge.sv
// Two-flop synchroniser for asynchronous pin inputs.
module sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      out  <= '0;
    end else begin
      meta <= in;
      out  <= meta;
    end
  end

endmodule

// File: rtl/gpio_ext.sv
// 16-pin GPIO controller on the 8-bit CSR bus: direction/output registers,
// debounced inputs, per-pin edge/level interrupts with W1C pending bits.
module gpio_ext
  import gpio_ext_pkg::*;
#(
  parameter logic [CSR_AW-1:0]    BASE_ADDR = 5'h0,
  parameter int unsigned          NUM_GPIOS = 16,
  parameter logic [NUM_GPIOS-1:0] DFL_STATE = '0,
  parameter logic [NUM_GPIOS-1:0] DFL_OE    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CSR_AW-1:0]    csr_a,
  input  logic [CSR_DW-1:0]    csr_di,
  input  logic                 csr_we,
  output logic [CSR_DW-1:0]    csr_do,
  input  logic [NUM_GPIOS-1:0] in,
  output logic [NUM_GPIOS-1:0] out,
  output logic [NUM_GPIOS-1:0] oe,
  output logic                 irq
);

  localparam logic [MAX_GPIOS-1:0]   PIN_MASK   = pin_mask(NUM_GPIOS);
  localparam logic [2*MAX_GPIOS-1:0] IMODE_MASK = imode_mask(NUM_GPIOS);

  logic [MAX_GPIOS-1:0]   dir_q, out_q, ie_q, ip_q;
  logic [MAX_GPIOS-1:0]   dir_n, out_n, ie_n, ip_n;
  logic [2*MAX_GPIOS-1:0] imode_q, imode_n;
  logic [DEBOUNCE_W-1:0]  deb_q, deb_n, deb_lim;
  logic                   irq_q;

  logic [NUM_GPIOS-1:0]   in_sync, filtered, toggle, ev;
  logic [MAX_GPIOS-1:0]   filt16, ev16;

  logic [CSR_AW:0]        diff;
  logic [OFF_W-1:0]       off;
  logic                   in_win, wr;
  logic [CSR_DW-1:0]      rd;

  // Window decode: offset 0..E above BASE_ADDR
  assign diff   = {1'b0, csr_a} - {1'b0, BASE_ADDR};
  assign off    = diff[OFF_W-1:0];
  assign in_win = ~diff[CSR_AW] & ~diff[CSR_AW-1] & (off != 4'hF);
  assign wr     = csr_we & in_win;

  assign deb_lim = (deb_q == '0) ? '0 : deb_q - DEBOUNCE_W'(1);

  sync_edge #(.W(NUM_GPIOS)) u_sync (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (in_sync)
  );

  for (genvar i = 0; i < NUM_GPIOS; i++) begin : g_pin
    gpio_debounce u_deb (
      .clk      (clk),
      .rst      (rst),
      .in_sync  (in_sync[i]),
      .limit    (deb_lim),
      .filtered (filtered[i]),
      .toggle_c (toggle[i])
    );

    // Event strobe; level mode pends every cycle the filtered value is high
    assign ev[i] = (imode_q[2*i +: 2] == IMODE_LEVEL) ? filtered[i] :
                   toggle[i] & ((imode_q[2*i +: 2] == IMODE_BOTH) |
                                ((imode_q[2*i +: 2] == IMODE_RISE) & ~filtered[i]) |
                                ((imode_q[2*i +: 2] == IMODE_FALL) &  filtered[i]));
  end

  assign filt16 = MAX_GPIOS'(filtered);
  assign ev16   = MAX_GPIOS'(ev);

  // Next-state for all CSRs; events are ORed after the W1C so set wins
  always_comb begin
    dir_n   = dir_q;
    out_n   = out_q;
    ie_n    = ie_q;
    ip_n    = ip_q;
    imode_n = imode_q;
    deb_n   = deb_q;
    if (wr) begin
      unique case (off)
        GPIO_DIR_LO:   dir_n[7:0]     = csr_di;
        GPIO_DIR_HI:   dir_n[15:8]    = csr_di;
        GPIO_OUT_LO:   out_n[7:0]     = csr_di;
        GPIO_OUT_HI:   out_n[15:8]    = csr_di;
        GPIO_IE_LO:    ie_n[7:0]      = csr_di;
        GPIO_IE_HI:    ie_n[15:8]     = csr_di;
        GPIO_IP_LO:    ip_n[7:0]      = ip_q[7:0] & ~csr_di;
        GPIO_IP_HI:    ip_n[15:8]     = ip_q[15:8] & ~csr_di;
        GPIO_IMODE_0:  imode_n[7:0]   = csr_di;
        GPIO_IMODE_1:  imode_n[15:8]  = csr_di;
        GPIO_IMODE_2:  imode_n[23:16] = csr_di;
        GPIO_IMODE_3:  imode_n[31:24] = csr_di;
        GPIO_DEBOUNCE: deb_n          = csr_di;
        default: ;
      endcase
    end
    ip_n    = (ip_n | ev16) & PIN_MASK;
    dir_n   = dir_n & PIN_MASK;
    out_n   = out_n & PIN_MASK;
    ie_n    = ie_n & PIN_MASK;
    imode_n = imode_n & IMODE_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q   <= MAX_GPIOS'(DFL_OE);
      out_q   <= MAX_GPIOS'(DFL_STATE);
      ie_q    <= '0;
      ip_q    <= '0;
      imode_q <= '0;
      deb_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      dir_q   <= dir_n;
      out_q   <= out_n;
      ie_q    <= ie_n;
      ip_q    <= ip_n;
      imode_q <= imode_n;
      deb_q   <= deb_n;
      irq_q   <= |(ip_n & ie_n);
    end
  end

  // Combinational read mux, zero outside the window
  always_comb begin
    rd = '0;
    unique case (off)
      GPIO_DIR_LO:   rd = dir_q[7:0];
      GPIO_DIR_HI:   rd = dir_q[15:8];
      GPIO_OUT_LO:   rd = out_q[7:0];
      GPIO_OUT_HI:   rd = out_q[15:8];
      GPIO_IN_LO:    rd = filt16[7:0];
      GPIO_IN_HI:    rd = filt16[15:8];
      GPIO_IE_LO:    rd = ie_q[7:0];
      GPIO_IE_HI:    rd = ie_q[15:8];
      GPIO_IP_LO:    rd = ip_q[7:0];
      GPIO_IP_HI:    rd = ip_q[15:8];
      GPIO_IMODE_0:  rd = imode_q[7:0];
      GPIO_IMODE_1:  rd = imode_q[15:8];
      GPIO_IMODE_2:  rd = imode_q[23:16];
      GPIO_IMODE_3:  rd = imode_q[31:24];
      GPIO_DEBOUNCE: rd = deb_q;
      default:       rd = '0;
    endcase
  end

  assign csr_do = in_win ? rd : '0;
  assign oe     = dir_q[NUM_GPIOS-1:0];
  assign out    = out_q[NUM_GPIOS-1:0];
  assign irq    = irq_q;

endmodule
